// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, branch/jump
// squash and multi-cycle data-memory freeze, plus stall/flush counters.
module pipeline_hazard_controller #(
    parameter int MEM_LATENCY = 3,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic [4:0]           ID_Rs,
    input  logic [4:0]           ID_Rt,
    input  logic                 ID_UsesRt,
    input  logic                 ID_Jump,
    input  logic                 EX_MemRead,
    input  logic [4:0]           EX_DestReg,
    input  logic                 EX_BranchTaken,
    input  logic                 MEM_MemAccess,
    output logic                 PC_Write,
    output logic                 IF_ID_Write,
    output logic                 IF_ID_Flush,
    output logic                 ID_EX_Write,
    output logic                 ID_EX_Flush,
    output logic                 EX_MEM_Write,
    output logic                 MEM_WB_Flush,
    output logic                 Mem_Busy,
    output logic [CNT_WIDTH-1:0] Stall_Count,
    output logic [CNT_WIDTH-1:0] Flush_Count
);

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    localparam bit         MULTI_CYCLE = (MEM_LATENCY > 1);
    localparam int         WAIT_INIT_I = MULTI_CYCLE ? MEM_LATENCY - 2 : 0;
    localparam logic [3:0] WAIT_INIT   = 4'(WAIT_INIT_I);

    state_t     state;
    logic [3:0] wait_cnt;
    logic       freeze;
    logic       load_use;
    logic       rs_hit;
    logic       rt_hit;

    assign freeze = ((state == RUN) && MEM_MemAccess && MULTI_CYCLE)
                  || ((state == MEM_WAIT) && (wait_cnt != 4'd0));

    assign rs_hit   = (EX_DestReg == ID_Rs);
    assign rt_hit   = ID_UsesRt && (EX_DestReg == ID_Rt);
    assign load_use = EX_MemRead && (EX_DestReg != 5'd0)
                    && (rs_hit || rt_hit);

    assign Mem_Busy = (state == MEM_WAIT);

    always_comb begin
        PC_Write     = 1'b1;
        IF_ID_Write  = 1'b1;
        IF_ID_Flush  = 1'b0;
        ID_EX_Write  = 1'b1;
        ID_EX_Flush  = 1'b0;
        EX_MEM_Write = 1'b1;
        MEM_WB_Flush = 1'b0;
        if (Reset) begin
            PC_Write     = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Write  = 1'b0;
            EX_MEM_Write = 1'b0;
            IF_ID_Flush  = 1'b1;
            ID_EX_Flush  = 1'b1;
            MEM_WB_Flush = 1'b1;
        end else if (freeze) begin
            // Hold everything upstream; WB only ever sees a completed access.
            PC_Write     = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Write  = 1'b0;
            EX_MEM_Write = 1'b0;
            MEM_WB_Flush = 1'b1;
        end else if (EX_BranchTaken) begin
            IF_ID_Flush = 1'b1;
            ID_EX_Flush = 1'b1;
        end else if (load_use) begin
            PC_Write    = 1'b0;
            IF_ID_Write = 1'b0;
            ID_EX_Flush = 1'b1;
        end else if (ID_Jump) begin
            IF_ID_Flush = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= RUN;
            wait_cnt    <= 4'd0;
            Stall_Count <= '0;
            Flush_Count <= '0;
        end else begin
            unique case (state)
                RUN: begin
                    if (freeze) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= WAIT_INIT;
                    end
                end
                MEM_WAIT: begin
                    if (wait_cnt != 4'd0) begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end else begin
                        state <= RUN;
                    end
                end
                default: begin
                    state    <= RUN;
                    wait_cnt <= 4'd0;
                end
            endcase
            if (!PC_Write && (Stall_Count != '1)) begin
                Stall_Count <= Stall_Count + 1'b1;
            end
            if (IF_ID_Flush && (Flush_Count != '1)) begin
                Flush_Count <= Flush_Count + 1'b1;
            end
        end
    end

endmodule
